// File: rtl/pwm_pkg.sv
// Shared constants, ramp state type and duty arithmetic helpers for the PWM ramp controller.
package pwm_pkg;

  localparam int DC_W    = 7;
  localparam int DC_MAX  = 100;
  localparam int STEP_W  = 4;
  localparam int ARITH_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  function automatic logic [DC_W-1:0] clamp_target(input logic [DC_W-1:0] t);
    return (t > DC_W'(DC_MAX)) ? DC_W'(DC_MAX) : t;
  endfunction

  function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

  // One step toward tgt, landing exactly on tgt when the step would overshoot it.
  function automatic logic [DC_W-1:0] step_toward(input logic [DC_W-1:0]   cur,
                                                  input logic [DC_W-1:0]   tgt,
                                                  input logic [STEP_W-1:0] stp,
                                                  input logic              rising);
    logic [ARITH_W-1:0] c;
    logic [ARITH_W-1:0] t;
    logic [ARITH_W-1:0] s;
    logic [ARITH_W-1:0] r;
    c = ARITH_W'(cur);
    t = ARITH_W'(tgt);
    s = ARITH_W'(stp);
    if (rising) begin
      r = c + s;
      if (r >= t) r = t;
    end else begin
      if (c < t + s) r = t;
      else           r = c - s;
    end
    return r[DC_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Divides period_tick pulses by DIV; fire marks the tick that completes a group of DIV.
module pwm_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic fire
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // fire is combinational so the owner can act on the same edge the counter wraps.
  assign fire = tick && !clr && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM duty command toward a requested target in fixed steps every DIV PWM periods.
// Option: PWM_RAMP_ABORT_ZERO_EN makes abort also drive dc to 0.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DC_W-1:0]   target,
  input  logic [STEP_W-1:0] step,
  input  logic              period_tick,
  input  logic              abort,
  output logic [DC_W-1:0]   dc,
  output logic              busy,
  output logic              done,
  output logic              up
);

  ramp_state_t       state;
  logic [DC_W-1:0]   tgt_q;
  logic [STEP_W-1:0] step_q;
  logic              fire;
  logic              div_clr;
  logic              div_tick;
  logic [DC_W-1:0]   new_tgt;
  logic [STEP_W-1:0] new_step;
  logic [DC_W-1:0]   next_dc;

  // Any start or abort restarts the period count; ticks only count while ramping.
  assign div_clr  = start | abort;
  assign div_tick = period_tick & (state == RAMP);

  assign new_tgt  = clamp_target(target);
  assign new_step = eff_step(step);
  assign next_dc  = step_toward(dc, tgt_q, step_q, up);

  pwm_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .tick  (div_tick),
    .fire  (fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dc     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      up     <= 1'b0;
      tgt_q  <= '0;
      step_q <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
`ifdef PWM_RAMP_ABORT_ZERO_EN
        dc    <= '0;
`endif
      end else if (start) begin
        // Retarget from the current dc; a target already reached completes immediately.
        tgt_q  <= new_tgt;
        step_q <= new_step;
        up     <= (new_tgt > dc);
        if (new_tgt == dc) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RAMP;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          RAMP: begin
            if (fire) begin
              dc <= next_dc;
              if (next_dc == tgt_q) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench: the driver pushes the expected outputs of every edge, a monitor pops and compares.
module tb_pwm_ramp_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] target;
  logic [3:0] step;
  logic       period_tick;
  logic       abort;
  logic [6:0] dc;
  logic       busy;
  logic       done;
  logic       up;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .DIV (DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .target      (target),
    .step        (step),
    .period_tick (period_tick),
    .abort       (abort),
    .dc          (dc),
    .busy        (busy),
    .done        (done),
    .up          (up)
  );

  typedef struct packed {
    logic [6:0] dc;
    logic       busy;
    logic       done;
    logic       up;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  // Reference model: duty as a plain integer, ticks counted since the last update.
  int m_dc = 0, m_tgt = 0, m_step = 0, m_ticks = 0;
  bit m_busy = 0, m_done = 0, m_up = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got dc=%0d busy=%b done=%b up=%b, want dc=%0d busy=%b done=%b up=%b",
               name, act.dc, act.busy, act.done, act.up, exp.dc, exp.busy, exp.done, exp.up);
    end
  endtask

  task automatic model_edge(input int rst, input int st, input int tg, input int sp,
                            input int tk, input int ab);
    int t;
    int s;
    if (rst != 0) begin
      m_dc = 0; m_tgt = 0; m_step = 0; m_ticks = 0;
      m_busy = 0; m_done = 0; m_up = 0;
      return;
    end
    m_done = 0;
    if (ab != 0) begin
      m_busy  = 0;
      m_ticks = 0;
`ifdef PWM_RAMP_ABORT_ZERO_EN
      m_dc    = 0;
`endif
    end else if (st != 0) begin
      t = (tg > 100) ? 100 : tg;
      s = (sp == 0) ? 1 : sp;
      m_tgt = t; m_step = s; m_ticks = 0;
      m_up  = (t > m_dc);
      if (t == m_dc) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_busy = 1;
      end
    end else if (m_busy && tk != 0) begin
      m_ticks++;
      if (m_ticks == DIV) begin
        m_ticks = 0;
        if (m_up) m_dc = (m_dc + m_step > m_tgt) ? m_tgt : m_dc + m_step;
        else      m_dc = (m_dc - m_step < m_tgt) ? m_tgt : m_dc - m_step;
        if (m_dc == m_tgt) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic drive(input int rst, input int st, input int tg, input int sp,
                       input int tk, input int ab);
    obs_t e;
    reset       = (rst != 0);
    start       = (st != 0);
    target      = 7'(tg);
    step        = 4'(sp);
    period_tick = (tk != 0);
    abort       = (ab != 0);
    model_edge(rst, st, tg, sp, tk, ab);
    e.dc   = 7'(m_dc);
    e.busy = m_busy;
    e.done = m_done;
    e.up   = m_up;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      idle(gap - 1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), obs_t'({dc, busy, done, up}), exp_q.pop_front());
      end
    end
  end

  initial begin
    cur_tag = "reset";
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    idle(2);

    cur_tag = "ramp_up_50";
    drive(0, 1, 50, 10, 0, 0);
    ticks(22, 8);
    idle(3);

    cur_tag = "ramp_down_5";
    drive(0, 1, 5, 15, 0, 0);
    ticks(14, 8);
    idle(3);

    cur_tag = "clamp_120_step0";
    drive(0, 1, 120, 0, 0, 0);
    ticks(390, 2);
    idle(3);

    cur_tag = "abort_with_start";
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 80, 10, 0, 0);
    ticks(12, 2);
    drive(0, 1, 90, 5, 0, 1);
    idle(3);
    ticks(8, 2);

    cur_tag = "retarget_down";
    drive(0, 1, 80, 10, 0, 0);
    ticks(6, 2);
    drive(0, 1, 20, 10, 0, 0);
    ticks(16, 2);
    idle(2);

    cur_tag = "start_at_target";
    drive(0, 1, 20, 7, 0, 0);
    idle(3);

    cur_tag = "reset_mid_ramp";
    drive(0, 1, 100, 10, 0, 0);
    ticks(16, 2);
    drive(1, 0, 0, 0, 1, 0);
    ticks(12, 2);

    cur_tag = "random";
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 599) == 0) ? 1 : 0,
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            $urandom_range(0, 127),
            $urandom_range(0, 15),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 79) == 0) ? 1 : 0);
    end
    idle(2);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter DIV, default 4: number of period_tick pulses between duty-cycle steps; legal range 1..256.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to ramp toward target.
REQ-005 target  input  7  requested duty in percent; values >100 are clamped to 100 at latch time.
REQ-006 step  input  4  duty increment per update in percent; 0 is treated as 1; sampled with start.
REQ-007 period_tick  input  1  one-cycle pulse per PWM period, driven from the PWM counter wrap.
REQ-008 abort  input  1  cancels an active ramp.
REQ-009 dc  output  7  registered duty command to the PWM generator, 0..100.
REQ-010 busy  output  1  high while in RAMP.
REQ-011 done  output  1  one-cycle pulse when dc reaches the latched target.
REQ-012 up  output  1  ramp direction; 1 = increasing, valid while busy.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and RAMP.
REQ-014 In IDLE, start SHALL latch the clamped target and the effective step, clear the tick counter and set up = (target > dc).
REQ-015 If the latched target equals dc at start, the FSM SHALL stay in IDLE and pulse done on the next edge, with busy never asserting.
REQ-016 Otherwise the FSM SHALL enter RAMP on the next edge, with busy = 1 from that edge.
REQ-017 In RAMP, each period_tick SHALL increment the tick counter; the tick that brings it to DIV SHALL update dc and reset the counter to 0.
REQ-018 Each update SHALL move dc by step toward the target, saturating exactly at the target with no overshoot and never leaving 0..100; arithmetic is 8-bit internally.
REQ-019 On the edge where dc becomes equal to target, the FSM SHALL go to IDLE, busy SHALL fall and done SHALL be high for exactly that one cycle.
REQ-020 A start in RAMP SHALL retarget: latch the new target and step, recompute up from the current dc, clear the tick counter, and keep dc unchanged on that edge.
REQ-021 abort SHALL return the FSM to IDLE on the next edge, clear busy and the tick counter, and produce no done pulse.
REQ-022 When start and abort are asserted in the same cycle, abort SHALL win and start SHALL be ignored.
REQ-023 period_tick in IDLE SHALL be ignored.
REQ-024 dc SHALL change only on a step update, on reset, or as described in REQ-031.

Reset
REQ-025 When reset is asserted: dc = 0, busy = 0, done = 0, up = 0, state = IDLE, tick counter = 0, latched target = 0.
REQ-026 Reset asserted mid-ramp SHALL take priority over all other inputs on that edge.

Configuration
REQ-027 Macro PWM_RAMP_ABORT_ZERO_EN SHALL be the only compile-time option.
REQ-028 With PWM_RAMP_ABORT_ZERO_EN defined, abort SHALL also force dc to 0 on the same edge (safe shutdown).
REQ-029 Without PWM_RAMP_ABORT_ZERO_EN, abort SHALL leave dc at its current value.
REQ-030 The macro SHALL NOT alter the port list.
REQ-031 The dc change caused by abort under PWM_RAMP_ABORT_ZERO_EN is the only exception to REQ-024.

Structure
REQ-032 Shared package pwm_pkg SHALL hold DC_W = 7, DC_MAX = 100, STEP_W = 4 and the ramp state enum typedef.
REQ-033 The tick counter SHALL be a sub-module pwm_tick_div with inputs clk, reset, clr, tick, a parameter DIV, and a one-cycle output fire.

Verification
REQ-034 Reset, then start with target = 50, step = 10, DIV = 4, and a period_tick every 8 cycles -> dc goes 10, 20, 30, 40, 50, each 4 ticks apart; done pulses once, on the edge where dc becomes 50.
REQ-035 From dc = 50, start with target = 5 and step = 15 -> up = 0; dc goes 35, 20, 5 with no undershoot; then done.
REQ-036 Start with target = 120 and step = 0 -> clamped to 100; dc rises by 1 per update; done when dc = 100.
REQ-037 Mid-ramp at dc = 30: abort and start in the same cycle -> IDLE, busy = 0, no done; dc = 30 without the macro, dc = 0 with PWM_RAMP_ABORT_ZERO_EN.
REQ-038 Mid-ramp toward 80 at dc = 40: start with target = 20 -> up = 0, tick counter cleared, dc descends to 20 and done pulses; then start with target = 20 -> done one cycle later and busy stays 0.
REQ-039 Reset asserted mid-ramp at dc = 60 -> on the next edge all outputs match REQ-025 and later period_ticks do not change dc.
